// File: rtl/xnor_popcnt_acc.sv
// Streaming XNOR-popcount accumulator producing a signed bipolar dot product per vector.
// Define XNOR_ACC_SAT_EN to clamp res_o to ACC_WIDTH and flag clipping on sat_o.
module xnor_popcnt_acc #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8,
   parameter int ACC_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [DATA_WIDTH-1:0] xnor_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [ACC_WIDTH-1:0]  res_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  sat_o
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam int PW    = LEN_WIDTH + CNT_W;
   localparam int RW    = PW + 2;
   localparam int XW    = (RW > ACC_WIDTH) ? RW : ACC_WIDTH;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                 state_reg, state_next;
   logic [PW-1:0]          p_reg, p_next;
   logic [LEN_WIDTH-1:0]   cnt_reg, cnt_next;
   logic [LEN_WIDTH-1:0]   len_reg, len_next;
   logic [ACC_WIDTH-1:0]   res_reg, res_next;
   logic                   sat_reg, sat_next;

   logic [CNT_W-1:0]       pop;
   logic [PW-1:0]          p_sum;
   logic [LEN_WIDTH-1:0]   len_eff;
   logic [LEN_WIDTH-1:0]   cnt_cur;
   logic [RW-1:0]          two_p;
   logic [RW-1:0]          l_dw;
   logic signed [RW-1:0]   r_full;
   logic signed [XW-1:0]   r_ext;
   logic                   accept;

   always_comb begin
      pop = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         pop = pop + CNT_W'(xnor_i[i]);
      end
   end

   assign accept  = in_valid_i && (state_reg != DONE);
   // The first beat of a vector supplies the length; zero is treated as one word.
   assign len_eff = (state_reg == IDLE) ? ((len_i == '0) ? LEN_WIDTH'(1) : len_i) : len_reg;
   assign cnt_cur = (state_reg == IDLE) ? LEN_WIDTH'(1) : cnt_reg + LEN_WIDTH'(1);
   assign p_sum   = ((state_reg == IDLE) ? '0 : p_reg) + PW'(pop);
   assign two_p   = {1'b0, p_sum, 1'b0};
   assign l_dw    = RW'(len_eff) * RW'(DATA_WIDTH);
   assign r_full  = $signed(two_p - l_dw);
   assign r_ext   = XW'(r_full);

`ifdef XNOR_ACC_SAT_EN
   logic signed [XW:0] r_cmp, max_v, min_v;
   assign r_cmp = (XW + 1)'(r_full);
   assign max_v = $signed({{(XW - ACC_WIDTH + 2){1'b0}}, {(ACC_WIDTH - 1){1'b1}}});
   assign min_v = ~max_v;

   always_comb begin
      res_next = r_ext[ACC_WIDTH-1:0];
      sat_next = 1'b0;
      if (r_cmp > max_v) begin
         res_next = max_v[ACC_WIDTH-1:0];
         sat_next = 1'b1;
      end else if (r_cmp < min_v) begin
         res_next = min_v[ACC_WIDTH-1:0];
         sat_next = 1'b1;
      end
   end
`else
   always_comb begin
      res_next = r_ext[ACC_WIDTH-1:0];
      sat_next = 1'b0;
   end
`endif

   logic [ACC_WIDTH-1:0] res_hold;
   logic                 sat_hold;

   always_comb begin
      state_next = state_reg;
      p_next     = p_reg;
      cnt_next   = cnt_reg;
      len_next   = len_reg;
      res_hold   = res_reg;
      sat_hold   = sat_reg;
      case (state_reg)
         IDLE, ACCUM: begin
            if (accept) begin
               p_next   = p_sum;
               cnt_next = cnt_cur;
               len_next = len_eff;
               if (cnt_cur == len_eff) begin
                  state_next = DONE;
                  res_hold   = res_next;
                  sat_hold   = sat_next;
               end else begin
                  state_next = ACCUM;
               end
            end
         end
         DONE: begin
            if (out_ready_i) begin
               state_next = IDLE;
               sat_hold   = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
         p_reg     <= '0;
         cnt_reg   <= '0;
         len_reg   <= '0;
         res_reg   <= '0;
         sat_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         p_reg     <= p_next;
         cnt_reg   <= cnt_next;
         len_reg   <= len_next;
         res_reg   <= res_hold;
         sat_reg   <= sat_hold;
      end
   end

   assign in_ready_o  = (state_reg != DONE);
   assign out_valid_o = (state_reg == DONE);
   assign res_o       = res_reg;
   assign sat_o       = sat_reg;

endmodule

// File: tb/tb_xnor_popcnt_acc.sv
// Directed bench for xnor_popcnt_acc: a 16-bit result instance plus an 8-bit one for clipping.
module tb_xnor_popcnt_acc;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [31:0] xnor_i;
   logic [7:0]  len_i;
   logic        in_valid_i;
   logic        out_ready_i;

   logic        in_ready_o, out_valid_o, sat_o;
   logic [15:0] res_o;
   logic        in_ready8, out_valid8, sat8;
   logic [7:0]  res8;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   xnor_popcnt_acc #(.DATA_WIDTH(32), .LEN_WIDTH(8), .ACC_WIDTH(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .xnor_i(xnor_i), .len_i(len_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .res_o(res_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .sat_o(sat_o)
   );

   xnor_popcnt_acc #(.DATA_WIDTH(32), .LEN_WIDTH(8), .ACC_WIDTH(8)) dut8 (
      .clk_i(clk_i), .rst_ni(rst_ni), .xnor_i(xnor_i), .len_i(len_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready8), .res_o(res8),
      .out_valid_o(out_valid8), .out_ready_i(out_ready_i), .sat_o(sat8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
   task automatic beat(input logic [31:0] w, input logic [7:0] l);
      xnor_i     = w;
      len_i      = l;
      in_valid_i = 1'b1;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_i); #1;
      end
   endtask

   task automatic drain(input string tag);
      out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      out_ready_i = 1'b0;
      chk({tag, "_ov_after"}, 32'(out_valid_o), 32'd0);
      chk({tag, "_rdy_after"}, 32'(in_ready_o), 32'd1);
   endtask

   initial begin
      rst_ni      = 1'b0;
      xnor_i      = '0;
      len_i       = '0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      #1;
      chk("rst_ov", 32'(out_valid_o), 32'd0);
      chk("rst_res", 32'(res_o), 32'd0);
      chk("rst_sat", 32'(sat_o), 32'd0);
      #22 rst_ni = 1'b1;
      @(posedge clk_i); #1;
      chk("rst_rdy", 32'(in_ready_o), 32'd1);

      // Single all-ones word: +32 with one cycle latency
      beat(32'hFFFF_FFFF, 8'd1);
      chk("l1_ov", 32'(out_valid_o), 32'd1);
      chk("l1_res", 32'(res_o), 32'h0020);
      chk("l1_rdy", 32'(in_ready_o), 32'd0);
      drain("l1");

      // Three words with gaps; later len_i values must be ignored
      beat(32'h0000_FFFF, 8'd3);
      chk("l3_ov_b1", 32'(out_valid_o), 32'd0);
      idle(2);
      chk("l3_ov_gap", 32'(out_valid_o), 32'd0);
      beat(32'h0000_0000, 8'd2);
      chk("l3_ov_b2", 32'(out_valid_o), 32'd0);
      idle(1);
      beat(32'hFFFF_FFFF, 8'd9);
      chk("l3_ov", 32'(out_valid_o), 32'd1);
      chk("l3_res", 32'(res_o), 32'h0000);

      // Backpressure with a beat offered: nothing consumed, result held
      xnor_i     = 32'hFFFF_FFFF;
      len_i      = 8'd1;
      in_valid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i); #1;
         chk("bp_rdy", 32'(in_ready_o), 32'd0);
         chk("bp_ov", 32'(out_valid_o), 32'd1);
         chk("bp_res", 32'(res_o), 32'h0000);
      end
      out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      chk("bp_ov_done", 32'(out_valid_o), 32'd0);
      chk("bp_rdy_done", 32'(in_ready_o), 32'd1);
      idle(2);
      chk("bp_no_beat", 32'(out_valid_o), 32'd0);

      // out_ready_i while idle is harmless
      out_ready_i = 1'b1;
      idle(1);
      out_ready_i = 1'b0;
      chk("idle_ordy_ov", 32'(out_valid_o), 32'd0);

      // Eight all-ones words: R=256 (wraps or clips in the 8-bit instance)
      for (int i = 0; i < 7; i++) beat(32'hFFFF_FFFF, 8'd8);
      chk("l8_ov_early", 32'(out_valid_o), 32'd0);
      beat(32'hFFFF_FFFF, 8'd8);
      chk("l8_ov", 32'(out_valid_o), 32'd1);
      chk("l8_res16", 32'(res_o), 32'h0100);
      chk("l8_sat16", 32'(sat_o), 32'd0);
      chk("l8_ov8", 32'(out_valid8), 32'd1);
`ifdef XNOR_ACC_SAT_EN
      chk("l8_res8", 32'(res8), 32'h7F);
      chk("l8_sat8", 32'(sat8), 32'd1);
`else
      chk("l8_res8", 32'(res8), 32'h00);
      chk("l8_sat8", 32'(sat8), 32'd0);
`endif
      drain("l8");
      chk("l8_sat8_clr", 32'(sat8), 32'd0);

      // Two zero words: -64
      beat(32'h0000_0000, 8'd2);
      beat(32'h0000_0000, 8'd2);
      chk("neg_res", 32'(res_o), 32'hFFC0);
      drain("neg");

      // Reset mid-vector discards it
      beat(32'hFFFF_FFFF, 8'd4);
      beat(32'hFFFF_FFFF, 8'd4);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_ov", 32'(out_valid_o), 32'd0);
      chk("mid_rst_res", 32'(res_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      beat(32'hFFFF_FFFF, 8'd4);
      beat(32'hFFFF_FFFF, 8'd4);
      chk("mid_rst_fresh_ov", 32'(out_valid_o), 32'd0);
      rst_ni = 1'b0;
      #1;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      beat(32'h0000_0000, 8'd1);
      chk("post_rst_ov", 32'(out_valid_o), 32'd1);
      chk("post_rst_res", 32'(res_o), 32'hFFE0);
      drain("post_rst");

      // len_i=0 acts as length 1
      beat(32'hAAAA_AAAA, 8'd0);
      chk("len0_ov", 32'(out_valid_o), 32'd1);
      chk("len0_res", 32'(res_o), 32'h0000);
      drain("len0");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/xnor_popcnt_acc.md
XNOR_POPCNT_ACC -- requirements
Module: xnor_popcnt_acc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each xnor word from the upstream xnor_unit.
REQ-002 SHALL have parameter LEN_WIDTH, default 8: width of the vector-length field (words per dot product).
REQ-003 SHALL have parameter ACC_WIDTH, default 16: width of the signed result.
REQ-004 SHALL have port clk_i, input, 1: the single clock, rising-edge active.
REQ-005 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port xnor_i, input, DATA_WIDTH: xnor word (c_o of xnor_unit).
REQ-007 SHALL have port len_i, input, LEN_WIDTH: words in the current vector, sampled on the first beat only.
REQ-008 SHALL have port in_valid_i, input, 1: xnor_i/len_i valid.
REQ-009 SHALL have port in_ready_o, output, 1: block accepts a beat.
REQ-010 SHALL have port res_o, output, ACC_WIDTH: signed bipolar dot product.
REQ-011 SHALL have port out_valid_o, output, 1: res_o valid.
REQ-012 SHALL have port out_ready_i, input, 1: consumer accepts res_o.
REQ-013 SHALL have port sat_o, output, 1: res_o was clipped (0 when XNOR_ACC_SAT_EN is undefined).

Function
REQ-014 SHALL accept a beat on a rising edge when in_valid_i and in_ready_o are both 1.
REQ-015 SHALL implement the states IDLE, ACCUM and DONE; in_ready_o SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-016 In IDLE, an accepted beat SHALL latch L = len_i (len_i = 0 treated as 1), set P = popcount(xnor_i), and set the beat count to 1.
REQ-017 From IDLE, the next state SHALL be DONE if L = 1, else ACCUM.
REQ-018 In ACCUM, each accepted beat SHALL add popcount(xnor_i) to P and increment the beat count, and len_i SHALL be ignored.
REQ-019 The state SHALL go to DONE on the beat that makes the beat count equal L.
REQ-020 The internal P SHALL be unsigned, wide enough for (2^LEN_WIDTH-1)*DATA_WIDTH, and SHALL never wrap.
REQ-021 On entry to DONE, the block SHALL register R = 2*P - L*DATA_WIDTH, computed signed at full internal width.
REQ-022 out_valid_o SHALL be 1 in the cycle after the last beat is accepted (latency 1), held with res_o stable until out_ready_i = 1.
REQ-023 Output handshake completion in DONE SHALL return the state to IDLE with out_valid_o = 0; no input beat is accepted in that cycle.
REQ-024 Without saturation, res_o SHALL be R modulo 2^ACC_WIDTH (two's complement truncation).
REQ-025 in_valid_i = 0 in ACCUM SHALL hold all state; gaps between beats are allowed.
REQ-026 out_ready_i while out_valid_o = 0 SHALL have no effect.

Reset
REQ-027 rst_ni = 0 SHALL immediately force state IDLE, P = 0, beat count = 0, L = 0, res_o = 0, out_valid_o = 0, sat_o = 0; in_ready_o = 1 after reset release.
REQ-028 Reset during ACCUM or DONE SHALL discard the partial vector or pending result; no result SHALL be emitted for it.

Configuration
REQ-029 With macro XNOR_ACC_SAT_EN defined, res_o SHALL clamp R to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], and sat_o SHALL be 1 with out_valid_o when clamping occurred.
REQ-030 With XNOR_ACC_SAT_EN undefined, REQ-024 wrap SHALL apply and sat_o SHALL be tied 0.

Verification (DATA_WIDTH=32, LEN_WIDTH=8, ACC_WIDTH=16 unless noted)
REQ-031 Bench SHALL cover: len_i=1, xnor_i=0xFFFFFFFF -> one cycle later out_valid_o=1, res_o=+32.
REQ-032 Bench SHALL cover: len_i=3, words 0x0000FFFF, 0x00000000, 0xFFFFFFFF with idle gaps -> res_o = 2*48-96 = 0, with no output before the third beat.
REQ-033 Bench SHALL cover: result pending, out_ready_i=0 for 5 cycles with in_valid_i=1 -> in_ready_o=0, res_o stable, no beat consumed; out_ready_i=1 -> IDLE next cycle.
REQ-034 Bench SHALL cover: ACC_WIDTH=8, len_i=8 of all-ones (R=256) -> with XNOR_ACC_SAT_EN, res_o=127 and sat_o=1; without it, res_o=0 and sat_o=0.
REQ-035 Bench SHALL cover: rst_ni pulsed low after 2 of 4 beats -> outputs zero immediately; a fresh len_i=1 vector of 0x00000000 -> res_o=-32.
REQ-036 Bench SHALL cover: len_i=0 with one beat 0xAAAAAAAA -> treated as length 1, res_o=0.
